// File: rtl/icache_ctrl.sv
// icache_ctrl: instruction-side cache responder for the fetch stage.
// Direct-mapped, read-only, 4 x 16-bit words per line. A hit answers in the
// same cycle; a miss fetches the whole line from main memory, installs it,
// and the fetch is then answered on the next compare.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_addr, i_rd  fetch word address and fetch request valid
//   i_inv         one-cycle pulse, invalidates all lines
//   instr         instruction word (16'h0000 unless instr_rdy)
//   instr_rdy     instr valid for current i_addr; low stalls the pipeline
//   mem_re        line read request to main memory
//   mem_addr      latched line address i_addr[15:2]
//   mem_rdy       memory has placed the line on mem_rd_data
//   mem_rd_data   line data, offset 0 in [15:0]
//   miss_cnt      misses started since reset, wraps
//
// state | meaning
// IDLE  | compare i_addr against the cache, start a fill on a miss
// FILL  | request outstanding, waiting for mem_rdy
module icache_ctrl #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic        i_inv,
    output logic [15:0] instr,
    output logic        instr_rdy,
    output logic        mem_re,
    output logic [13:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [63:0] mem_rd_data,
    output logic [15:0] miss_cnt
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 14 - IDX;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [63:0]       data_q [LINES];
    logic              mem_re_q, mem_re_d;
    logic [13:0]       mem_addr_q, mem_addr_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic              fill_we;

    logic [1:0]        offset;
    logic [IDX-1:0]    index;
    logic [TAGW-1:0]   tag;
    logic [IDX-1:0]    fill_idx;
    logic [TAGW-1:0]   fill_tag;
    logic [63:0]       line_data;
    logic              hit;

    assign offset    = i_addr[1:0];
    assign index     = i_addr[IDX+1:2];
    assign tag       = i_addr[15:IDX+2];
    // The line being filled is identified entirely by the latched request.
    assign fill_idx  = mem_addr_q[IDX-1:0];
    assign fill_tag  = mem_addr_q[13:IDX];
    assign line_data = data_q[index];
    assign hit       = i_rd & valid_q[index] & (tag_q[index] == tag);

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        mem_re_d   = mem_re_q;
        mem_addr_d = mem_addr_q;
        miss_cnt_d = miss_cnt_q;
        fill_we    = 1'b0;
        instr_rdy  = 1'b0;
        instr      = 16'h0000;

        // Invalidate first so a fill completing in the same cycle still
        // leaves its own line valid.
        if (i_inv) begin
            valid_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                instr_rdy = hit;
                if (hit) begin
                    instr = line_data[{offset, 4'b0000} +: 16];
                end
                if (i_rd && !hit) begin
                    state_d    = S_FILL;
                    mem_re_d   = 1'b1;
                    mem_addr_d = i_addr[15:2];
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end
            S_FILL: begin
                if (mem_rdy) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    mem_re_d          = 1'b0;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag/data arrays carry no reset; validity alone decides a hit.
    always_ff @(posedge clk) begin
        if (fill_we && !rst) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rd_data;
        end
    end

    assign mem_re   = mem_re_q;
    assign mem_addr = mem_addr_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scenarios followed by randomized fetch traffic,
// checked against a behavioural model that tracks which memory line is
// resident in each slot and what the outstanding request is.
module tb_icache_ctrl;

    localparam int LINES = 8;

    logic        clk;
    logic        rst;
    logic [15:0] i_addr;
    logic        i_rd;
    logic        i_inv;
    logic [15:0] instr;
    logic        instr_rdy;
    logic        mem_re;
    logic [13:0] mem_addr;
    logic        mem_rdy;
    logic [63:0] mem_rd_data;
    logic [15:0] miss_cnt;

    icache_ctrl #(.LINES(LINES)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .i_rd        (i_rd),
        .i_inv       (i_inv),
        .instr       (instr),
        .instr_rdy   (instr_rdy),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_rdy     (mem_rdy),
        .mem_rd_data (mem_rd_data),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory image, word addressed.
    logic [15:0] mem_img [65536];

    // Reference model: resident line address per slot, outstanding request.
    logic        m_vld  [LINES];
    logic [13:0] m_line [LINES];
    logic        m_fill;
    logic [13:0] m_req;
    logic [15:0] m_miss;
    int          rdy_wait;
    int          delay_cfg;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
        m_fill = 1'b0;
        m_req  = '0;
        m_miss = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic rd, input logic [15:0] addr, input logic inv, input logic rs);
        logic [13:0] ln;
        logic [15:0] base;
        int          slot;
        logic        hitm;
        logic        rdy;
        logic        exp_rdy;
        logic [15:0] exp_instr;

        ln   = addr[15:2];
        slot = int'(ln) % LINES;
        hitm = m_vld[slot] && (m_line[slot] == ln);
        rdy  = 1'b0;
        if (m_fill) begin
            if (rdy_wait == 0) rdy = 1'b1;
            else rdy_wait--;
        end else if ($urandom_range(0, 7) == 0) begin
            rdy = 1'b1;
        end

        i_rd    = rd;
        i_addr  = addr;
        i_inv   = inv;
        rst     = rs;
        mem_rdy = rdy;
        if (m_fill && rdy) begin
            base = {m_req, 2'b00};
            mem_rd_data = {mem_img[base + 16'd3], mem_img[base + 16'd2],
                           mem_img[base + 16'd1], mem_img[base]};
        end else begin
            mem_rd_data = {$urandom, $urandom};
        end

        @(negedge clk);
        exp_rdy   = !m_fill && rd && hitm;
        exp_instr = exp_rdy ? mem_img[addr] : 16'h0000;
        check("instr_rdy", 32'(instr_rdy), 32'(exp_rdy));
        check("instr",     32'(instr),     32'(exp_instr));
        check("mem_re",    32'(mem_re),    32'(m_fill));
        check("mem_addr",  32'(mem_addr),  32'(m_req));
        check("miss_cnt",  32'(miss_cnt),  32'(m_miss));

        if (rs) begin
            model_reset();
        end else if (m_fill) begin
            if (inv) for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
            if (rdy) begin
                m_vld[int'(m_req) % LINES]  = 1'b1;
                m_line[int'(m_req) % LINES] = m_req;
                m_fill = 1'b0;
            end
        end else begin
            if (inv) for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
            if (rd && !hitm) begin
                m_fill   = 1'b1;
                m_req    = ln;
                m_miss   = m_miss + 16'd1;
                rdy_wait = (delay_cfg < 0) ? int'($urandom_range(0, 4)) : delay_cfg;
            end
        end

        @(posedge clk);
        #1;
    endtask

    logic [15:0] ra;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rdy_wait = 0;
        delay_cfg = 0;
        for (int a = 0; a < 65536; a++) mem_img[a] = 16'($urandom);
        mem_img[16'h0000] = 16'h1111;
        mem_img[16'h0001] = 16'h2222;
        mem_img[16'h0002] = 16'h3333;
        mem_img[16'h0003] = 16'h4444;
        mem_img[16'h0020] = 16'hAAAA;

        rst = 1'b1; i_rd = 1'b0; i_addr = '0; i_inv = 1'b0;
        mem_rdy = 1'b0; mem_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Cold miss, memory answers on the 4th fill cycle, then same-line hits.
        delay_cfg = 3;
        repeat (6) step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0);

        // Conflict at index 0, then the original line misses again.
        delay_cfg = 1;
        repeat (4) step(1'b1, 16'h0020, 1'b0, 1'b0);
        repeat (4) step(1'b1, 16'h0000, 1'b0, 1'b0);
        check("miss_cnt_conflict", 32'(miss_cnt), 32'd3);

        // Address change while the fill is outstanding.
        delay_cfg = 2;
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        repeat (8) step(1'b1, 16'h0004, 1'b0, 1'b0);

        // Invalidate, then reset in the middle of a fill.
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        delay_cfg = 10;
        repeat (3) step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b1);
        repeat (6) step(1'b0, 16'h0000, 1'b0, 1'b0);
        check("miss_cnt_after_rst", 32'(miss_cnt), 32'd0);

        // Invalidate in the same cycle as mem_rdy keeps the filled line.
        delay_cfg = 0;
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b1, 1'b0);
        check("inv_fill_hit", 32'(instr_rdy), 32'd1);
        step(1'b1, 16'h0000, 1'b0, 1'b0);

        // Randomized traffic, mostly within a small window to get hits.
        delay_cfg = -1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) != 0) ra = 16'($urandom_range(0, 127));
            else ra = 16'($urandom);
            step(($urandom_range(0, 7) != 0), ra,
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
